// File: rtl/nav_mission_sequencer.sv
// Table-driven mission sequencer that steps the Navigation block through a programmable step table.
// Optional feature macro NAV_SEQ_SINGLE_STEP_EN adds STEP_GO, which holds COMP until a STEP_GO rising edge.
module nav_mission_sequencer #(
  parameter int          STEPS          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  localparam int         SW_I           = $clog2(STEPS)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic            ABORT,
  input  logic            NEXT_FLAG,
  input  logic [7:0]      DISTANCE_SIDE_FRONT,
  input  logic            WR_EN,
  input  logic [SW_I-1:0] WR_ADDR,
  input  logic [31:0]     WR_DATA,
`ifdef NAV_SEQ_SINGLE_STEP_EN
  input  logic            STEP_GO,
`endif
  output logic [4:0]      COMMAND,
  output logic [7:0]      PATH,
  output logic [7:0]      COMPARE_DISTANCE,
  output logic [1:0]      RUN_FLAG,
  output logic [SW_I-1:0] STEP_IDX,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERROR
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_EXEC, S_COMP, S_FINISH, S_ERR} state_t;

  typedef struct packed {
    logic [4:0] command;
    logic [1:0] mode;
    logic [7:0] path;
    logic [7:0] operand;
    logic [3:0] next;
    logic       last;
    logic [3:0] rsvd;
  } entry_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  entry_t      table_q [STEPS];
  entry_t      cur;
  logic        start_q, next_q;
  logic        start_rise, next_rise, timeout_hit, comp_adv, table_wr_ok;
  logic [31:0] to_cnt;
  logic [8:0]  diff, sum;
  logic [7:0]  cmp_dist;
  logic        unused_bits;

  assign cur         = table_q[STEP_IDX];
  assign start_rise  = START & ~start_q;
  assign next_rise   = NEXT_FLAG & ~next_q;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
  assign table_wr_ok = (state == S_IDLE) || (state == S_FINISH) || (state == S_ERR);
  assign unused_bits = ^{cur.next, cur.rsvd};

`ifdef NAV_SEQ_SINGLE_STEP_EN
  logic go_q;
  assign comp_adv = STEP_GO & ~go_q;
`else
  assign comp_adv = 1'b1;
`endif

  // 9-bit intermediates expose the borrow/carry used for saturation.
  assign diff = {1'b0, cur.operand} - {1'b0, DISTANCE_SIDE_FRONT};
  assign sum  = {1'b0, cur.operand} + {1'b0, DISTANCE_SIDE_FRONT};

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    cmp_dist = cur.operand;
    case (cur.mode)
      2'b01:   cmp_dist = DISTANCE_SIDE_FRONT;
      2'b10:   cmp_dist = diff[8] ? 8'd0 : diff[7:0];
      2'b11:   cmp_dist = sum[8] ? 8'hFF : sum[7:0];
      default: cmp_dist = cur.operand;
    endcase
  end

  // NOTE: the step table is reset like any other register, so an async reset wipes the mission.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
    end else if (WR_EN && table_wr_ok) begin
      table_q[WR_ADDR] <= entry_t'(WR_DATA);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state            <= S_IDLE;
      start_q          <= 1'b0;
      next_q           <= 1'b0;
      to_cnt           <= '0;
      COMMAND          <= '0;
      PATH             <= '0;
      COMPARE_DISTANCE <= '0;
      RUN_FLAG         <= 2'b00;
      STEP_IDX         <= '0;
      BUSY             <= 1'b0;
      DONE             <= 1'b0;
      ERROR            <= 1'b0;
`ifdef NAV_SEQ_SINGLE_STEP_EN
      go_q             <= 1'b0;
`endif
    end else begin
      start_q <= START;
      next_q  <= NEXT_FLAG;
`ifdef NAV_SEQ_SINGLE_STEP_EN
      go_q    <= STEP_GO;
`endif
      if (ABORT) begin
        state    <= S_IDLE;
        COMMAND  <= '0;
        RUN_FLAG <= 2'b00;
        STEP_IDX <= '0;
        BUSY     <= 1'b0;
        DONE     <= 1'b0;
        ERROR    <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_FINISH, S_ERR: begin
            if (start_rise) begin
              state    <= S_INIT;
              COMMAND  <= '0;
              RUN_FLAG <= 2'b00;
              STEP_IDX <= '0;
              BUSY     <= 1'b1;
              DONE     <= 1'b0;
              ERROR    <= 1'b0;
            end
          end
          S_INIT: begin
            COMMAND          <= cur.command;
            PATH             <= cur.path;
            COMPARE_DISTANCE <= cmp_dist;
            to_cnt           <= '0;
            RUN_FLAG         <= 2'b01;
            state            <= S_EXEC;
          end
          S_EXEC: begin
            // Completion outranks a timeout landing on the same cycle.
            if (next_rise) begin
              state    <= S_COMP;
              RUN_FLAG <= 2'b10;
`ifdef NAV_SEQ_SINGLE_STEP_EN
              COMMAND  <= '0;
`endif
            end else if (timeout_hit) begin
              state    <= S_ERR;
              RUN_FLAG <= 2'b11;
              COMMAND  <= '0;
              BUSY     <= 1'b0;
              ERROR    <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 32'd1;
            end
          end
          S_COMP: begin
            if (comp_adv) begin
              if (cur.last) begin
                state   <= S_FINISH;
                COMMAND <= '0;
                BUSY    <= 1'b0;
                DONE    <= 1'b1;
              end else begin
                STEP_IDX <= cur.next[SW_I-1:0];
                RUN_FLAG <= 2'b00;
                state    <= S_INIT;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
